// File: rtl/flags_stack_if.sv
// ALU flag-unit bundle: update/stack controls in, registered flags and stack status out.
// Latency: none (wires only). Backpressure: none; the unit accepts a command every cycle.
interface flags_stack_if #(
    parameter int WIDTH = 4,
    parameter int CW    = 3
);
    logic             enable;
    logic [WIDTH-1:0] alu_result;
    logic             carry;
    logic             overflow;
    logic [3:0]       update_mask;
    logic             push;
    logic             pop;
    logic             clear;

    logic             zero_out;
    logic             carry_out;
    logic             neg_out;
    logic             ovf_out;
    logic [3:0]       flags_out;
    logic [CW-1:0]    stack_count;
    logic             stack_full;
    logic             stack_empty;
    logic             stack_err;

    modport master (
        output enable, alu_result, carry, overflow, update_mask, push, pop, clear,
        input  zero_out, carry_out, neg_out, ovf_out, flags_out,
               stack_count, stack_full, stack_empty, stack_err
    );

    modport slave (
        input  enable, alu_result, carry, overflow, update_mask, push, pop, clear,
        output zero_out, carry_out, neg_out, ovf_out, flags_out,
               stack_count, stack_full, stack_empty, stack_err
    );
endinterface

// File: rtl/flags_stack.sv
// Z/C/N/V flag register with masked update and a LIFO save stack; 1-cycle latency.
// No backpressure: push on full / pop on empty is dropped and sets a sticky error.
module flags_stack #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic         clk,
    input  logic         reset,
    flags_stack_if.slave bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [3:0]    flags_q, flags_d, cand, upd;
    logic [3:0]    stack_mem [DEPTH];
    logic [CW-1:0] count_q, count_d;
    logic          err_q, err_d;
    logic [AW-1:0] wr_idx, rd_idx;
    logic          full, empty, push_only, pop_only, do_push, do_pop;

    assign full      = (count_q == CW'(DEPTH));
    assign empty     = (count_q == '0);
    // Simultaneous push and pop cancel out: no stack movement and no error.
    assign push_only = bus.push & ~bus.pop;
    assign pop_only  = bus.pop & ~bus.push;
    assign do_push   = push_only & ~full;
    assign do_pop    = pop_only & ~empty;

    // At count==DEPTH the low bits wrap, but only the read index is used then.
    assign wr_idx = count_q[AW-1:0];
    assign rd_idx = wr_idx - AW'(1);

    assign cand = {bus.overflow, bus.alu_result[WIDTH-1], bus.carry, ~|bus.alu_result};
    assign upd  = bus.enable ? ((bus.update_mask & cand) | (~bus.update_mask & flags_q))
                             : flags_q;

    always_comb begin
        flags_d = upd;
        if (do_pop)
            flags_d = stack_mem[rd_idx];
        if (bus.clear)
            flags_d = '0;
    end

    always_comb begin
        count_d = count_q;
        if (do_push)
            count_d = count_q + CW'(1);
        else if (do_pop)
            count_d = count_q - CW'(1);
    end

    always_comb begin
        err_d = err_q | (push_only & full) | (pop_only & empty);
        if (bus.clear)
            err_d = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flags_q <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            flags_q <= flags_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    // Entries are never reset; they are only read below the live count.
    always_ff @(posedge clk) begin
        if (do_push && !reset)
            stack_mem[wr_idx] <= flags_q;
    end

    assign bus.zero_out    = flags_q[0];
    assign bus.carry_out   = flags_q[1];
    assign bus.neg_out     = flags_q[2];
    assign bus.ovf_out     = flags_q[3];
    assign bus.flags_out   = flags_q;
    assign bus.stack_count = count_q;
    assign bus.stack_full  = full;
    assign bus.stack_empty = empty;
    assign bus.stack_err   = err_q;
endmodule

// File: tb/tb_flags_stack.sv
// Randomised + directed bench for flags_stack; a queue-based reference model
// feeds a scoreboard that a separate monitor drains one cycle after each command.
module tb_flags_stack;
    localparam int WIDTH = 4;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    typedef struct {
        logic [3:0]    flags;
        logic [CW-1:0] count;
        logic          err;
        logic          full;
        logic          empty;
    } exp_t;

    logic clk = 1'b0;
    logic reset;

    flags_stack_if #(.WIDTH(WIDTH), .CW(CW)) bus ();

    flags_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CW(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    exp_t       sb [$];
    exp_t       mon_e;
    logic [3:0] m_flags;
    logic [3:0] m_stack [$];
    logic       m_err;
    int         tests = 0;
    int         fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t snapshot();
        exp_t e;
        e.flags = m_flags;
        e.count = CW'(m_stack.size());
        e.err   = m_err;
        e.full  = (m_stack.size() == DEPTH);
        e.empty = (m_stack.size() == 0);
        return e;
    endfunction

    // Reference: flags as a 4-bit value, stack as a queue whose back is the top.
    task automatic model_step(input logic rst, en, input logic [WIDTH-1:0] alu,
                              input logic c, v, input logic [3:0] m,
                              input logic pu, po, cl);
        logic [3:0] cnd, nf;
        logic       e;
        if (rst) begin
            m_flags = '0;
            m_stack.delete();
            m_err = 1'b0;
            return;
        end
        cnd = {v, alu[WIDTH-1], c, (alu == 0)};
        nf  = m_flags;
        e   = 1'b0;
        if (en)
            for (int i = 0; i < 4; i++)
                if (m[i]) nf[i] = cnd[i];
        if (pu && !po) begin
            if (m_stack.size() < DEPTH) m_stack.push_back(m_flags);
            else e = 1'b1;
        end
        if (po && !pu) begin
            if (m_stack.size() > 0) nf = m_stack.pop_back();
            else e = 1'b1;
        end
        if (cl) begin
            nf = '0;
            m_err = 1'b0;
        end else begin
            m_err = m_err | e;
        end
        m_flags = nf;
    endtask

    task automatic drive(input logic rst, en, input logic [WIDTH-1:0] alu,
                         input logic c, v, input logic [3:0] m,
                         input logic pu, po, cl);
        @(negedge clk);
        reset = rst;
        bus.enable = en; bus.alu_result = alu; bus.carry = c; bus.overflow = v;
        bus.update_mask = m; bus.push = pu; bus.pop = po; bus.clear = cl;
        model_step(rst, en, alu, c, v, m, pu, po, cl);
        sb.push_back(snapshot());
    endtask

    task automatic idle();
        drive(0, 0, '0, 0, 0, 4'h0, 0, 0, 0);
    endtask

    task automatic after_edge();
        @(posedge clk);
        #2;
    endtask

    // Monitor: every output cycle is compared against the oldest expectation.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                mon_e = sb.pop_front();
                check("flags_out", bus.flags_out, mon_e.flags);
                check("flag_bits", {bus.ovf_out, bus.neg_out, bus.carry_out, bus.zero_out}, mon_e.flags);
                check("stack_count", bus.stack_count, mon_e.count);
                check("stack_err", bus.stack_err, mon_e.err);
                check("stack_full", bus.stack_full, mon_e.full);
                check("stack_empty", bus.stack_empty, mon_e.empty);
            end
        end
    end

    initial begin
        reset = 1'b1;
        bus.enable = 0; bus.alu_result = '0; bus.carry = 0; bus.overflow = 0;
        bus.update_mask = '0; bus.push = 0; bus.pop = 0; bus.clear = 0;
        m_flags = '0; m_err = 1'b0;

        drive(1, 1, 4'h5, 1, 1, 4'hF, 1, 0, 0);
        drive(1, 0, '0, 0, 0, 4'h0, 0, 1, 0);

        // Load Z and C from an all-zero result with carry.
        drive(0, 1, 4'h0, 1, 0, 4'hF, 0, 0, 0);
        after_edge();
        check("load_all_flags", bus.flags_out, 4'b0011);

        // Masked update touches N only.
        drive(0, 1, 4'h8, 0, 1, 4'b0100, 0, 0, 0);
        after_edge();
        check("masked_n_only", bus.flags_out, 4'b0111);

        // Five pushes with a concurrent update, so each saved value differs.
        drive(0, 1, 4'h9, 0, 1, 4'hF, 1, 0, 0);
        drive(0, 1, 4'h0, 1, 0, 4'hF, 1, 0, 0);
        drive(0, 1, 4'h3, 1, 1, 4'hF, 1, 0, 0);
        drive(0, 1, 4'hC, 1, 0, 4'hF, 1, 0, 0);
        drive(0, 1, 4'h2, 0, 0, 4'hF, 1, 0, 0);
        after_edge();
        check("fill_count", bus.stack_count, 4);
        check("fill_full", bus.stack_full, 1'b1);
        check("fill_err", bus.stack_err, 1'b1);
        for (int i = 0; i < DEPTH; i++)
            drive(0, 0, '0, 0, 0, 4'h0, 0, 1, 0);
        after_edge();
        check("drain_empty", bus.stack_empty, 1'b1);
        check("drain_last", bus.flags_out, 4'b0111);

        // Underflow: update still applies, error sets, clear removes it.
        drive(0, 0, '0, 0, 0, 4'h0, 0, 0, 1);
        drive(0, 1, 4'h1, 0, 0, 4'hF, 0, 1, 0);
        after_edge();
        check("underflow_flags", bus.flags_out, 4'b0000);
        check("underflow_err", bus.stack_err, 1'b1);
        drive(0, 0, '0, 0, 0, 4'h0, 0, 0, 1);
        after_edge();
        check("clear_err", bus.stack_err, 1'b0);

        // Push and pop together at count 2.
        drive(0, 1, 4'hF, 1, 1, 4'hF, 1, 0, 0);
        drive(0, 1, 4'h0, 0, 0, 4'hF, 1, 0, 0);
        drive(0, 0, 4'h7, 1, 1, 4'hF, 1, 1, 0);
        after_edge();
        check("pushpop_count", bus.stack_count, 2);
        check("pushpop_flags", bus.flags_out, 4'b0001);
        check("pushpop_err", bus.stack_err, 1'b0);

        // Async reset between edges while a push is pending at count 3.
        drive(0, 1, 4'hA, 0, 1, 4'hF, 1, 0, 0);
        @(negedge clk);
        reset = 1'b0; bus.push = 1; bus.pop = 0; bus.clear = 0; bus.enable = 1;
        #2 reset = 1'b1;
        #1;
        check("async_count", bus.stack_count, 0);
        check("async_flags", bus.flags_out, 4'b0000);
        check("async_empty", bus.stack_empty, 1'b1);
        check("async_full", bus.stack_full, 1'b0);
        model_step(1, 0, '0, 0, 0, 4'h0, 0, 0, 0);
        sb.push_back(snapshot());

        for (int n = 0; n < 600; n++) begin
            drive(($urandom_range(0, 79) == 0),
                  $urandom_range(0, 1),
                  WIDTH'($urandom),
                  $urandom_range(0, 1),
                  $urandom_range(0, 1),
                  4'($urandom),
                  ($urandom_range(0, 2) == 0),
                  ($urandom_range(0, 2) == 0),
                  ($urandom_range(0, 15) == 0));
        end

        idle();
        repeat (3) @(posedge clk);
        #2;
        check("scoreboard_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/flags_stack.md
FLAGS_STACK -- requirements
Module: flags_stack

Interface
REQ-001 Parameter WIDTH, default 4, ALU result width in bits (>=2).
REQ-002 Parameter DEPTH, default 4, flag save-stack depth in entries (>=2).
REQ-003 Parameter CW, default $clog2(DEPTH+1), stack count width.
REQ-004 Clock and reset: one clock; reset is asynchronous and active-high.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 enable  in  1  flag update strobe.
REQ-008 alu_result  in  WIDTH  ALU result used for Z and N.
REQ-009 carry  in  1  ALU carry-out.
REQ-010 overflow  in  1  ALU signed overflow.
REQ-011 update_mask  in  4  per-flag write mask: bit0=Z, bit1=C, bit2=N, bit3=V.
REQ-012 push  in  1  save current flags to stack.
REQ-013 pop  in  1  restore flags from stack top.
REQ-014 clear  in  1  synchronous clear of flags and error.
REQ-015 zero_out, carry_out, neg_out, ovf_out  out  1 each  registered flags.
REQ-016 flags_out  out  4  {ovf_out, neg_out, carry_out, zero_out}.
REQ-017 stack_count  out  CW  occupied entries, 0..DEPTH.
REQ-018 stack_full, stack_empty  out  1 each  count==DEPTH, count==0 (combinational from count).
REQ-019 stack_err  out  1  sticky overflow/underflow error.

Function
REQ-020 Flag candidates: Z = (alu_result == 0); N = alu_result[WIDTH-1]; C = carry; V = overflow.
REQ-021 enable=1 sampled at rising edge: each flag with mask bit 1 loads its candidate; mask bit 0 holds; visible one cycle after sample.
REQ-022 enable=0: all flags hold regardless of mask and data.
REQ-023 Push with not full: stack[count] <= current registered flags (pre-update value of this edge); count +1.
REQ-024 Push with full: entry dropped, count unchanged, stack_err <= 1.
REQ-025 Pop with not empty: flags <= stack[count-1]; count -1; overrides enable update in same cycle.
REQ-026 Pop with empty: flags unchanged (enable update still applies), stack_err <= 1.
REQ-027 push and pop same cycle: stack and count unchanged, no error; enable update applies normally.
REQ-028 Push and enable same cycle: pushed value = old flags; flags take new update.
REQ-029 clear=1: flags <= 0, stack_err <= 0; highest priority over pop/enable; stack contents and count unaffected; push in same cycle still saves old flags.
REQ-030 Priority for flag register: clear > valid pop > enable > hold.
REQ-031 stack_err remains 1 until clear or reset.
REQ-032 Stack is LIFO; no wrap-around; count saturates at 0 and DEPTH.

Reset
REQ-033 reset=1 asynchronously forces all flags 0, stack_count 0, stack_err 0, stack_empty 1, stack_full 0 (stack_full 1 never at reset).
REQ-034 Stack entry contents need not be reset; unreadable while empty.
REQ-035 Reset asserted mid-operation aborts any push/pop/update in that cycle; first update after release at the first rising edge with reset=0.
REQ-036 All inputs ignored while reset=1.

Verification (WIDTH=4, DEPTH=4)
REQ-037 Reset then enable=1, mask=4'hF, alu_result=0, carry=1, overflow=0 -> next cycle flags_out=4'b0011.
REQ-038 flags=4'b0011, enable=1, mask=4'b0100, alu_result=4'h8 -> flags_out=4'b0111; zero/carry unchanged.
REQ-039 Push 5 times with distinct flags -> count 4, stack_full=1, stack_err=1 after fifth; then 4 pops restore values in reverse order, stack_empty=1.
REQ-040 Empty stack, pop with enable=1, mask=4'hF, alu_result=4'h1 -> flags_out=4'b0000, stack_err=1; clear -> stack_err=0.
REQ-041 count=2, push+pop same cycle -> count stays 2, flags unchanged, stack_err=0.
REQ-042 Assert reset between clock edges during push at count=3 -> count 0, flags 0 immediately, no edge needed.
